wide_add_seq: RTL and testbench
===============================

# wide_add_seq

Multi-cycle sequencer that performs WORDS×32-bit add/subtract by driving one shared `bit32Adder` instance, one 32-bit word per clock, least-significant word first, with the carry chained through a register. It sits between an operand producer and a result consumer, each with a valid/ready handshake. It gives the lab datapath wide-integer arithmetic (default 128-bit) without replicating the adder.

## Interface
- `WORDS`, 4: number of 32-bit words per operand; legal range 1..16.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and `op_sub` are valid.
- `in_ready` output 1: block accepts a new operation.
- `op_sub` input 1: 0 = A+B, 1 = A−B.
- `a` input WORDS*32: operand A, unsigned or two's complement.
- `b` input WORDS*32: operand B.
- `out_valid` output 1: result fields are valid.
- `out_ready` input 1: consumer takes the result.
- `sum` output WORDS*32: result.
- `cout` output 1: final carry out of the top word; for subtract, 1 = no borrow.
- `ovf` output 1: signed overflow.

## Operation
- State machine with three states: IDLE, RUN, DONE. The reset state is IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch A into `a_reg`.
  - Latch `b_reg` = `op_sub` ? ~B : B.
  - Set `carry_reg` = `op_sub`, word index `idx` = 0, and clear `sum` to 0.
  - Go to RUN.
- **RUN:**
  - Adder inputs: In1 = `a_reg` word `idx`, In2 = `b_reg` word `idx`, Cin = `carry_reg`.
  - On each edge, write the adder Sum into `sum` word `idx`, load `carry_reg` with the adder Cout, and set `idx`++.
  - When `idx` == WORDS−1, also load `cout` with the adder Cout.
  - Also on that edge, load `ovf` = (a_msb == b_eff_msb) && (sum_msb != a_msb), using the top-word MSBs. Then go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `sum`, `cout` and `ovf` are held stable.
  - On `out_valid && out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; operands are not sampled again.
- Arithmetic is modulo 2^(WORDS*32). The carry out of the top word appears only on `cout`.
- WORDS=1 is a legal configuration: RUN lasts exactly one cycle.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, state=IDLE, `idx`=0, `carry_reg`=0.
- All outputs are registered. `in_ready` and `out_valid` decode directly from state.
- Latency:
  - The accept edge is edge 0.
  - `out_valid` rises after edge WORDS, i.e. WORDS cycles after acceptance.
- Throughput: one operation per WORDS+2 cycles when `out_ready` is held high.
  - `in_ready` reasserts in the cycle after the result handshake.
  - There is no same-cycle accept/retire overlap.
- Backpressure: DONE persists indefinitely while `out_ready`=0, with the outputs unchanged.
- Reset asserted in any state, including mid-RUN:
  - The operation is aborted immediately and asynchronously.
  - All outputs return to their reset values.
  - The next operation after release is computed correctly.
- The adder is combinational. The RUN critical path is one 32-bit add plus register setup.

## Structure
- Shared include `adder_defs.vh` holds:
  - `WORD_W`=32.
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
- Exactly one sub-module: the existing `bit32Adder`, instantiated once. No other adder logic is permitted.
- Word select and word write use `idx`*32 indexed part-selects. `idx` width is clog2(WORDS), minimum 1.

## Test plan
All scenarios use WORDS=4 unless noted.
1. Reset hold, then release:
   - Outputs are all 0 and `in_ready`=1.
   - `in_valid` pulses before release are not accepted.
2. Add across word boundaries:
   - Stimulus: a=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1.
   - Result: `sum`=128'h0000_0001_0000_0000_0000_0000_0000_0000, `cout`=0, `ovf`=0.
   - `out_valid` rises exactly 4 cycles after accept.
3. Full wrap:
   - Stimulus: a=all ones, b=1, add.
   - Result: `sum`=0, `cout`=1, `ovf`=0.
4. Subtract:
   - 0−1: `sum`=all ones, `cout`=0, `ovf`=0.
   - 128'h8000…0 − 1: `sum`=128'h7FFF…F, `cout`=1, `ovf`=1.
5. Backpressure:
   - Hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands.
   - `sum`/`cout`/`ovf` stay stable and `in_ready`=0.
   - After the handshake, IDLE is reached and the new operands are accepted only then.
6. Mid-RUN reset:
   - Assert `rst_n`=0 when `idx`=2: outputs clear immediately.
   - After release, scenario 2 repeated gives the correct result.
   - Repeat scenario 2 with WORDS=1 and 32-bit operands 0xFFFFFFFF+1: `sum`=0, `cout`=1, latency 1.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide add/subtract sequencer: word width,
// state encodings and the word-index width helper.
package wide_add_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // A single-word configuration still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_adder.sv
// The shared 32-bit combinational adder driven once per RUN cycle by the
// sequencer. Port names follow the existing datapath library.
module bit32Adder (
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout
);

  assign {Cout, Sum} = {1'b0, In1} + {1'b0, In2} + {32'b0, Cin};

endmodule

// File: rtl/wide_add_seq.sv
// WORDS x 32-bit add/subtract, one word per clock LSW first, carry chained
// through a register into one shared bit32Adder. Valid/ready on both sides.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic [WORDS*WORD_W-1:0] a,
  input  logic [WORDS*WORD_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W    = WORDS * WORD_W;
  localparam int IDXW = idx_width(WORDS);
  localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [WORD_W-1:0] add_in1, add_in2, add_sum;
  logic              add_cout;

  assign add_in1 = a_q[idx_q*WORD_W +: WORD_W];
  assign add_in2 = b_q[idx_q*WORD_W +: WORD_W];

  bit32Adder u_adder (
    .In1  (add_in1),
    .In2  (add_in2),
    .Cin  (carry_q),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here, inject the 1 as carry-in.
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[idx_q*WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST) begin
          // On the last word the adder output is the top word of the result.
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[WORD_W-1] != a_q[W-1]);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench: a 4-word and a 1-word sequencer side by side, hand-computed
// expected results, inputs driven on the falling edge and sampled there too.
module tb_wide_add_seq;

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MSB  = {1'b1, 127'b0};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [127:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [127:0] sum;

  logic         in_valid1 = 1'b0, op_sub1 = 1'b0, out_ready1 = 1'b0;
  logic [31:0]  a1 = '0, b1 = '0;
  logic         in_ready1, out_valid1, cout1, ovf1;
  logic [31:0]  sum1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  wide_add_seq #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_sub(op_sub1), .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one operation for a single accept edge (called at a falling edge).
  task automatic issue4(input logic sub, input logic [127:0] va, input logic [127:0] vb);
    chk("issue_ready", in_ready, 1'b1);
    in_valid = 1'b1; op_sub = sub; a = va; b = vb;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait4(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("timeout4", out_valid, 1'b1);
  endtask

  task automatic retire4;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("retire_ready", in_ready, 1'b1);
    chk("retire_valid", out_valid, 1'b0);
  endtask

  task automatic op4(input string tag, input logic sub, input logic [127:0] va,
                     input logic [127:0] vb, input logic [127:0] es, input logic ec,
                     input logic eo);
    int lat;
    issue4(sub, va, vb);
    wait4(lat);
    chk({tag, "_lat"}, 128'(lat), 128'd4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    retire4();
  endtask

  initial begin
    int lat;
    logic [127:0] held;

    // Reset hold with in_valid pulses that must be ignored.
    repeat (2) @(negedge clk);
    in_valid = 1'b1; a = 128'h55; b = 128'h22;
    @(negedge clk);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_flags", {cout, ovf}, 2'b00);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1'b1);
    chk("post_rst_valid", out_valid, 1'b0);

    op4("carry_chain", 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
        128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
    op4("wrap", 1'b0, ONES, 128'd1, 128'd0, 1'b1, 1'b0);
    op4("sub_0m1", 1'b1, 128'd0, 128'd1, ONES, 1'b0, 1'b0);
    op4("sub_min", 1'b1, MSB, 128'd1, ~MSB, 1'b1, 1'b1);
    op4("add_ovf", 1'b0, ~MSB, 128'd1, MSB, 1'b0, 1'b1);

    // Backpressure: DONE holds while new operands are offered.
    issue4(1'b1, 128'd0, 128'd1);
    wait4(lat);
    held = sum;
    chk("bp_first", held, ONES);
    in_valid = 1'b1; op_sub = 1'b0; a = 128'd5; b = 128'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum", sum, ONES);
      chk("bp_flags", {cout, ovf, out_valid, in_ready}, 4'b0010);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    wait4(lat);
    chk("bp_lat", 128'(lat), 128'd4);
    chk("bp_sum2", sum, 128'd8);
    retire4();

    // Abort mid-RUN at idx=2; previous cout=1/ovf=1 results are still in the flops.
    op4("pre_abort", 1'b1, MSB, 128'd1, ~MSB, 1'b1, 1'b1);
    issue4(1'b0, 128'h1111_1111_2222_2222_3333_3333_4444_4444, 128'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, '0);
    chk("abort_state", {in_ready, out_valid, cout, ovf}, 4'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op4("after_abort", 1'b0, 128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1,
        128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);

    // Single-word configuration.
    chk("w1_ready", in_ready1, 1'b1);
    in_valid1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w1_timeout", out_valid1, 1'b1);
    chk("w1_lat", 128'(lat), 128'd1);
    chk("w1_sum", sum1, 32'd0);
    chk("w1_flags", {cout1, ovf1}, 2'b10);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("w1_retire", {in_ready1, out_valid1}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
